mem_arbiter: RTL

//  Parametrised N-master to 1-slave arbiter for the valid/ready memory handshake used by the CPU, display and cache ports.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// N-master to 1-slave arbiter for the valid/ready memory handshake (round-robin or fixed priority).
// Optional macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts with err and 0xDEADBEEF read data.
module mem_arbiter #(
  parameter int NM       = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NM-1:0]      m_valid,
  output logic [NM-1:0]      m_ready,
  input  logic [NM*AW-1:0]   m_addr,
  input  logic [NM*DW/8-1:0] m_wmask,
  input  logic [NM*DW-1:0]   m_wdata,
  output logic [DW-1:0]      m_rdata,
  output logic               s_valid,
  input  logic               s_ready,
  output logic [AW-1:0]      s_addr,
  output logic [DW/8-1:0]    s_wmask,
  output logic [DW-1:0]      s_wdata,
  input  logic [DW-1:0]      s_rdata,
  output logic               err
);

  localparam int GW = $clog2(NM);
  localparam int BW = DW / 8;

  if (NM < 2 || NM > 8 || DW % 8 != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("mem_arbiter: parameter out of range");
  end

  // Handshake: a master raises m_valid and holds it until its one-cycle m_ready
  // pulse; the slave sees s_valid for the whole BUSY phase and answers with a
  // one-cycle s_ready, which completes the transaction in that same cycle.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] ptr, ptr_nxt;
  logic [GW-1:0] winner;
  logic [GW:0]   rr_idx;
  logic          found;
  logic          done;
  logic          timeout_hit;
  logic          finish;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_idx = '0;
    if (ARB_MODE == 1) begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (m_valid[GW'(i)]) winner = GW'(i);
      end
    end else begin
      // Wrap by explicit compare so non power-of-two NM never aliases.
      for (int k = 0; k < NM; k++) begin
        rr_idx = {1'b0, ptr} + (GW+1)'(k);
        if (rr_idx >= (GW+1)'(NM)) rr_idx = rr_idx - (GW+1)'(NM);
        if (!found && m_valid[rr_idx[GW-1:0]]) begin
          winner = rr_idx[GW-1:0];
          found  = 1'b1;
        end
      end
    end
  end

  assign s_valid = (state == BUSY);
  assign done    = s_valid && s_ready;
  assign finish  = done || timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] timer;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  // Timer reads 0 in the first BUSY cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign timeout_hit = s_valid && !s_ready && (timer == 16'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign err = timeout_hit;

  always_comb begin
    m_ready = '0;
    if (finish) m_ready[grant] = 1'b1;
  end

  assign m_rdata = timeout_hit ? {(DW/32){32'hDEADBEEF}} : s_rdata;
  assign s_addr  = m_addr[int'(grant)*AW +: AW];
  assign s_wdata = m_wdata[int'(grant)*DW +: DW];
  assign s_wmask = s_valid ? m_wmask[int'(grant)*BW +: BW] : '0;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|m_valid) begin
          grant_nxt = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (finish) begin
          ptr_nxt   = (grant == GW'(NM - 1)) ? '0 : grant + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule
